// File: rtl/ps2_keyboard_emulator_if.sv
// rtl/ps2_keyboard_emulator_if.sv - key event inputs and PS/2 bus lines of the keyboard emulator
interface ps2_keyboard_emulator_if;
  logic       key_action;
  logic [7:0] scan_code;
  logic       key_release;
  logic       key_extended;
  logic       host_inhibit;
  logic       ps2_clk;
  logic       ps2_dat;

  modport master (
    output key_action, scan_code, key_release, key_extended, host_inhibit,
    input  ps2_clk, ps2_dat
  );

  modport slave (
    input  key_action, scan_code, key_release, key_extended, host_inhibit,
    output ps2_clk, ps2_dat
  );
endinterface

// File: rtl/ps2_keyboard_emulator.sv
// rtl/ps2_keyboard_emulator.sv - PS/2 device-side keyboard emulator with byte FIFO and frame serialiser
module ps2_keyboard_emulator #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  ps2_keyboard_emulator_if.slave        kbd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [15:0]                   frames_sent
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DIV_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
  localparam logic [3:0]    STOP_IDX = 4'd10;

  typedef enum logic [2:0] {IDLE, SETUP, CLK_LOW, GAP, INHIBIT} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      idx_q, idx_d;
  logic            clk_q, clk_d;
  logic            dat_q, dat_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     frames_q, frames_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];

  logic            pop;
  logic            accept;
  logic            can_start;
  logic            abort;
  logic [CW-1:0]   needed;
  logic [CW-1:0]   free;
  logic [7:0]      seq [3];
  logic [7:0]      head;

  // Bit i of the 11-bit frame: start, eight data bits LSB first, odd parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] i);
    logic r;
    if (i == 4'd0)      r = 1'b0;
    else if (i <= 4'd8) r = b[3'(i - 4'd1)];
    else if (i == 4'd9) r = ~^b;
    else                r = 1'b1;
    return r;
  endfunction

  assign head = mem_q[rd_ptr_q];

  // Expand a key event into its byte sequence and write it atomically, or drop it whole.
  always_comb begin
    needed = CW'(1) + CW'(kbd.key_extended) + CW'(kbd.key_release);
    free   = CW'(FIFO_DEPTH) - count_q;
    accept = kbd.key_action && (free >= needed);
    seq[0] = kbd.scan_code;
    seq[1] = kbd.scan_code;
    seq[2] = kbd.scan_code;
    case ({kbd.key_extended, kbd.key_release})
      2'b01:   seq[0] = 8'hF0;
      2'b10:   seq[0] = 8'hE0;
      2'b11:   begin seq[0] = 8'hE0; seq[1] = 8'hF0; end
      default: seq[0] = kbd.scan_code;
    endcase
    mem_d = mem_q;
    if (accept) begin
      for (int k = 0; k < 3; k++) begin
        if (CW'(k) < needed) mem_d[wr_ptr_q + AW'(k)] = seq[k];
      end
    end
    wr_ptr_d   = accept ? wr_ptr_q + AW'(needed) : wr_ptr_q;
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (accept ? needed : '0) - CW'(pop);
    overflow_d = overflow_q | (kbd.key_action & ~accept);
  end

  // Frame serialiser: next state, line levels, bit index and pop/frame counting.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    clk_d     = clk_q;
    dat_d     = dat_q;
    frames_d  = frames_q;
    pop       = 1'b0;
    can_start = (count_q != '0) && !kbd.host_inhibit;
    abort     = kbd.host_inhibit && (idx_q != STOP_IDX);
    case (state_q)
      IDLE: begin
        clk_d = 1'b1;
        dat_d = 1'b1;
        if (can_start) begin
          state_d = SETUP; idx_d = '0; timer_d = '0; dat_d = 1'b0;
        end
      end
      SETUP: begin
        if (abort) begin
          state_d = INHIBIT; clk_d = 1'b1; dat_d = 1'b1; timer_d = '0; idx_d = '0;
        end else if (timer_q == DIV_LAST) begin
          state_d = CLK_LOW; clk_d = 1'b0; timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      CLK_LOW: begin
        if (abort) begin
          state_d = INHIBIT; clk_d = 1'b1; dat_d = 1'b1; timer_d = '0; idx_d = '0;
        end else if (timer_q == DIV_LAST) begin
          clk_d   = 1'b1;
          timer_d = '0;
          if (idx_q != STOP_IDX) begin
            idx_d   = idx_q + 4'd1;
            dat_d   = frame_bit(head, idx_q + 4'd1);
            state_d = SETUP;
          end else begin
            pop      = 1'b1;
            frames_d = frames_q + 16'd1;
            dat_d    = 1'b1;
            state_d  = GAP;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      // The idle-exit check is folded into the gap end so the lines stay idle for exactly GAP_CYCLES.
      GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (can_start) begin
            state_d = SETUP; idx_d = '0; dat_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      INHIBIT: begin
        if (kbd.host_inhibit) begin
          timer_d = '0;
        end else if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (can_start) begin
            state_d = SETUP; idx_d = '0; dat_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE; clk_d = 1'b1; dat_d = 1'b1;
      end
    endcase
  end

  // Control and status registers; reset aborts any frame and discards queued bytes.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      clk_q      <= 1'b1;
      dat_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      frames_q   <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      clk_q      <= clk_d;
      dat_q      <= dat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      frames_q   <= frames_d;
    end
  end

  // Byte storage needs no reset; pointers define which entries are valid.
  always_ff @(posedge CLOCK_50) begin
    mem_q <= mem_d;
  end

  assign kbd.ps2_clk  = clk_q;
  assign kbd.ps2_dat  = dat_q;
  assign busy         = (state_q != IDLE) && (state_q != INHIBIT);
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign frames_sent  = frames_q;
endmodule

// File: tb/tb_ps2_keyboard_emulator.sv
// tb/tb_ps2_keyboard_emulator.sv - self-checking bench for ps2_keyboard_emulator
module tb_ps2_keyboard_emulator;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int GAP_CYCLES = 8;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        busy;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [15:0] frames_sent;

  ps2_keyboard_emulator_if kbd();

  ps2_keyboard_emulator #(
    .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .kbd(kbd), .busy(busy),
    .fifo_count(fifo_count), .overflow(overflow), .frames_sent(frames_sent)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Cycle stamp used to time line transitions.
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Reference data: expected byte stream and what the host side observed.
  logic [7:0]  exp_q[$];
  logic [10:0] rx_q[$];
  int          start_q[$];
  int          stop_q[$];
  int          fall_q[$];
  logic        prev_c = 1'b1, prev_d = 1'b1, stop_pend = 1'b0;
  int          nb = 0, hi_cnt = 0, start_t = 0;
  logic [10:0] cur;

  // Host-side receiver: samples the lines mid-cycle, collects bits on ps2_clk falling edges.
  always @(negedge CLOCK_50) begin : mon
    logic c, d;
    c = kbd.ps2_clk;
    d = kbd.ps2_dat;
    if (prev_c && c && prev_d && !d && nb == 0) start_t = cyc;
    if (prev_c && !c) begin
      cur[nb] = d;
      nb++;
      fall_q.push_back(cyc);
      if (nb == 11) begin
        rx_q.push_back(cur);
        start_q.push_back(start_t);
        nb = 0;
        stop_pend = 1'b1;
      end
    end
    if (!prev_c && c && stop_pend) begin
      stop_q.push_back(cyc);
      stop_pend = 1'b0;
    end
    hi_cnt = c ? hi_cnt + 1 : 0;
    if (hi_cnt > 2 * CLK_DIV && nb != 0) nb = 0;
    prev_c = c;
    prev_d = d;
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic p;
    p = (($countones(b) % 2) == 0);
    return {1'b1, p, b, 1'b0};
  endfunction

  function automatic void model_push(input logic [7:0] code, input logic rel, input logic ext);
    if (ext) exp_q.push_back(8'hE0);
    if (rel) exp_q.push_back(8'hF0);
    exp_q.push_back(code);
  endfunction

  task automatic clear_mon();
    rx_q.delete(); start_q.delete(); stop_q.delete(); fall_q.delete();
    nb = 0; stop_pend = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b1; kbd.host_inhibit = 1'b0; kbd.key_action = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    clear_mon();
    exp_q.delete();
  endtask

  task automatic push(input logic [7:0] code, input logic rel, input logic ext);
    kbd.scan_code = code; kbd.key_release = rel; kbd.key_extended = ext; kbd.key_action = 1'b1;
    @(negedge CLOCK_50);
    kbd.key_action = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge CLOCK_50);
      k++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    checks++; if (kbd.ps2_clk !== 1'b1) begin errors++; $display("FAIL reset_clk got=%b exp=1", kbd.ps2_clk); end
    checks++; if (kbd.ps2_dat !== 1'b1) begin errors++; $display("FAIL reset_dat got=%b exp=1", kbd.ps2_dat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL reset_frames got=%0d exp=0", frames_sent); end
    reset = 1'b0;
  endtask

  task automatic test_single_make();
    int bad;
    do_reset();
    push(8'h1B, 1'b0, 1'b0); model_push(8'h1B, 1'b0, 1'b0);
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
    checks++; if (kbd.ps2_dat !== 1'b1) begin errors++; $display("FAIL single_early_dat got=%b exp=1", kbd.ps2_dat); end
    @(negedge CLOCK_50);
    checks++; if (kbd.ps2_dat !== 1'b0) begin errors++; $display("FAIL single_start_dat got=%b exp=0", kbd.ps2_dat); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    wait_frames(1, 400);
    repeat (20) @(negedge CLOCK_50);
    checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL single_nframes got=%0d exp=1", rx_q.size()); end
    if (rx_q.size() >= 1) begin
      checks++; if (rx_q[0] !== frame_of(exp_q[0])) begin errors++; $display("FAIL single_frame got=%b exp=%b", rx_q[0], frame_of(exp_q[0])); end
    end
    bad = 0;
    for (int i = 1; i < fall_q.size(); i++) if (fall_q[i] - fall_q[i-1] != 2 * CLK_DIV) bad++;
    checks++; if (bad !== 0 || fall_q.size() !== 11) begin errors++; $display("FAIL single_fall_spacing got=%0d bad of %0d exp=0 of 11", bad, fall_q.size()); end
    if (stop_q.size() >= 1 && start_q.size() >= 1) begin
      checks++; if (stop_q[0] - start_q[0] !== 22 * CLK_DIV) begin errors++; $display("FAIL single_frame_len got=%0d exp=%0d", stop_q[0] - start_q[0], 22 * CLK_DIV); end
    end
    checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL single_frames_sent got=%0d exp=1", frames_sent); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_count_end got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_release();
    do_reset();
    push(8'h1B, 1'b1, 1'b0); model_push(8'h1B, 1'b1, 1'b0);
    wait_frames(2, 600);
    repeat (20) @(negedge CLOCK_50);
    checks++; if (rx_q.size() !== 2) begin errors++; $display("FAIL release_nframes got=%0d exp=2", rx_q.size()); end
    for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== frame_of(exp_q[i])) begin errors++; $display("FAIL release_frame%0d got=%b exp=%b", i, rx_q[i], frame_of(exp_q[i])); end
    end
    if (rx_q.size() >= 1) begin
      checks++; if (rx_q[0][9] !== 1'b1) begin errors++; $display("FAIL release_f0_parity got=%b exp=1", rx_q[0][9]); end
    end
    if (start_q.size() >= 2 && stop_q.size() >= 1) begin
      checks++; if (start_q[1] - stop_q[0] !== GAP_CYCLES) begin errors++; $display("FAIL release_gap got=%0d exp=%0d", start_q[1] - stop_q[0], GAP_CYCLES); end
    end
    checks++; if (frames_sent !== 16'd2) begin errors++; $display("FAIL release_frames_sent got=%0d exp=2", frames_sent); end
  endtask

  task automatic test_ext_release();
    do_reset();
    push(8'h75, 1'b1, 1'b1); model_push(8'h75, 1'b1, 1'b1);
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL ext_count got=%0d exp=3", fifo_count); end
    wait_frames(3, 900);
    repeat (20) @(negedge CLOCK_50);
    checks++; if (rx_q.size() !== 3) begin errors++; $display("FAIL ext_nframes got=%0d exp=3", rx_q.size()); end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== frame_of(exp_q[i])) begin errors++; $display("FAIL ext_frame%0d got=%b exp=%b", i, rx_q[i], frame_of(exp_q[i])); end
    end
    if (rx_q.size() >= 3) begin
      checks++; if (rx_q[2][9] !== 1'b0) begin errors++; $display("FAIL ext_75_parity got=%b exp=0", rx_q[2][9]); end
    end
    checks++; if (frames_sent !== 16'd3) begin errors++; $display("FAIL ext_frames_sent got=%0d exp=3", frames_sent); end
  endtask

  task automatic test_overflow();
    logic [7:0] code;
    do_reset();
    kbd.host_inhibit = 1'b1;
    for (int i = 0; i < 7; i++) begin
      code = 8'($urandom);
      push(code, 1'b0, 1'b0); model_push(code, 1'b0, 1'b0);
    end
    repeat (3) @(negedge CLOCK_50);
    checks++; if (fifo_count !== 4'd7) begin errors++; $display("FAIL ovf_count7 got=%0d exp=7", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow); end
    checks++; if (busy !== 1'b0 || kbd.ps2_dat !== 1'b1) begin errors++; $display("FAIL ovf_inhibit_idle got=%b%b exp=01", busy, kbd.ps2_dat); end
    push(8'h2A, 1'b1, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    checks++; if (fifo_count !== 4'd7) begin errors++; $display("FAIL ovf_count_after_drop got=%0d exp=7", fifo_count); end
    code = 8'($urandom);
    push(code, 1'b0, 1'b0); model_push(code, 1'b0, 1'b0);
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count_full got=%0d exp=8", fifo_count); end
    push(8'h33, 1'b0, 1'b0);
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count_full_drop got=%0d exp=8", fifo_count); end
    kbd.host_inhibit = 1'b0;
    wait_frames(8, 8 * 120);
    repeat (20) @(negedge CLOCK_50);
    checks++; if (rx_q.size() !== 8) begin errors++; $display("FAIL ovf_nframes got=%0d exp=8", rx_q.size()); end
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== frame_of(exp_q[i])) begin errors++; $display("FAIL ovf_frame%0d got=%b exp=%b", i, rx_q[i], frame_of(exp_q[i])); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL ovf_count_end got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_inhibit_abort();
    int k;
    do_reset();
    push(8'h1C, 1'b0, 1'b0); model_push(8'h1C, 1'b0, 1'b0);
    k = 0;
    while (fall_q.size() < 5 && k < 200) begin @(negedge CLOCK_50); k++; end
    checks++; if (kbd.ps2_clk !== 1'b0) begin errors++; $display("FAIL abort_in_low got=%b exp=0", kbd.ps2_clk); end
    kbd.host_inhibit = 1'b1;
    @(negedge CLOCK_50);
    checks++; if (kbd.ps2_clk !== 1'b1 || kbd.ps2_dat !== 1'b1) begin errors++; $display("FAIL abort_lines got=%b%b exp=11", kbd.ps2_clk, kbd.ps2_dat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    repeat (15) @(negedge CLOCK_50);
    checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL abort_frames got=%0d exp=0", frames_sent); end
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL abort_count got=%0d exp=1", fifo_count); end
    kbd.host_inhibit = 1'b0;
    k = 0;
    do begin @(negedge CLOCK_50); k++; end while (kbd.ps2_dat !== 1'b0 && k < 50);
    checks++; if (k !== GAP_CYCLES) begin errors++; $display("FAIL abort_restart_delay got=%0d exp=%0d", k, GAP_CYCLES); end
    wait_frames(1, 400);
    repeat (20) @(negedge CLOCK_50);
    checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL abort_nframes got=%0d exp=1", rx_q.size()); end
    if (rx_q.size() >= 1) begin
      checks++; if (rx_q[0] !== frame_of(8'h1C)) begin errors++; $display("FAIL abort_resent got=%b exp=%b", rx_q[0], frame_of(8'h1C)); end
    end
    checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL abort_frames_end got=%0d exp=1", frames_sent); end
  endtask

  task automatic test_reset_mid_frame();
    int k;
    do_reset();
    kbd.host_inhibit = 1'b1;
    for (int i = 0; i < 3; i++) push(8'($urandom), 1'b1, 1'b1);
    checks++; if (overflow !== 1'b1 || fifo_count !== 4'd6) begin errors++; $display("FAIL rmid_setup got=%b/%0d exp=1/6", overflow, fifo_count); end
    kbd.host_inhibit = 1'b0;
    k = 0;
    while (fall_q.size() < 7 && k < 400) begin @(negedge CLOCK_50); k++; end
    checks++; if (kbd.ps2_clk !== 1'b0) begin errors++; $display("FAIL rmid_in_low got=%b exp=0", kbd.ps2_clk); end
    reset = 1'b1;
    @(negedge CLOCK_50);
    checks++; if (kbd.ps2_clk !== 1'b1 || kbd.ps2_dat !== 1'b1) begin errors++; $display("FAIL rmid_lines got=%b%b exp=11", kbd.ps2_clk, kbd.ps2_dat); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rmid_count got=%0d exp=0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow got=%b exp=0", overflow); end
    checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL rmid_frames got=%0d exp=0", frames_sent); end
    reset = 1'b0;
    clear_mon();
    repeat (300) @(negedge CLOCK_50);
    checks++; if (rx_q.size() !== 0 || fall_q.size() !== 0) begin errors++; $display("FAIL rmid_quiet got=%0d edges exp=0", fall_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int gap, need, k;
    logic [7:0] code;
    logic rel, ext;
    do_reset();
    for (int e = 0; e < 40; e++) begin
      gap = $urandom_range(0, 30);
      if ($urandom_range(0, 4) == 0) begin
        kbd.host_inhibit = 1'b1;
        repeat ($urandom_range(1, 20)) @(negedge CLOCK_50);
        kbd.host_inhibit = 1'b0;
      end
      repeat (gap) @(negedge CLOCK_50);
      code = 8'($urandom);
      rel  = 1'($urandom_range(0, 1));
      ext  = 1'($urandom_range(0, 1));
      need = 1 + int'(rel) + int'(ext);
      k = 0;
      while (exp_q.size() - rx_q.size() + 1 + need > FIFO_DEPTH && k < 3000) begin
        @(negedge CLOCK_50); k++;
      end
      push(code, rel, ext); model_push(code, rel, ext);
    end
    wait_frames(exp_q.size(), 20000);
    repeat (30) @(negedge CLOCK_50);
    checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_nframes got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== frame_of(exp_q[i])) begin errors++; $display("FAIL b2b_frame%0d got=%b exp=%b", i, rx_q[i], frame_of(exp_q[i])); end
    end
    checks++; if (frames_sent !== 16'(exp_q.size())) begin errors++; $display("FAIL b2b_frames_sent got=%0d exp=%0d", frames_sent, exp_q.size()); end
    checks++; if (overflow !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL b2b_end_state got=%b/%0d exp=0/0", overflow, fifo_count); end
  endtask

  initial begin
    reset = 1'b1;
    kbd.key_action = 1'b0; kbd.scan_code = 8'h00; kbd.key_release = 1'b0;
    kbd.key_extended = 1'b0; kbd.host_inhibit = 1'b0;
    test_reset();
    test_single_make();
    test_release();
    test_ext_release();
    test_overflow();
    test_inhibit_abort();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
